// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - 4-digit 7-segment scan controller with sequential binary-to-BCD conversion
//
// Purpose: accepts a binary score through a load handshake, converts it to
// BCD with a double-dabble FSM, then time-multiplexes one shared segment
// decoder across four digits with leading-zero blanking and a blinking
// FEVER mode.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   load        latch value_in (accepted only while busy=0)
//   value_in    14-bit binary score, values above 9999 clamp to 9999
//   fever       level, selects the blinking "F" display
//   busy        conversion in progress
//   digit_value decoder value: 0-9 digit, 4'hA = "F", 4'hF = blank
//   digit_sel   one-hot digit enable, bit 0 = least-significant digit
module seven_seg_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [13:0] value_in,
  input  logic        fever,
  output logic        busy,
  output logic [3:0]  digit_value,
  output logic [3:0]  digit_sel
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t        state, state_nx;
  logic          busy_nx;
  logic [13:0]   bin_q, bin_nx;
  logic [15:0]   bcd_q, bcd_nx, adj;
  logic [15:0]   disp_q, disp_nx;
  logic [3:0]    iter_q, iter_nx;

  logic [PW-1:0] presc_q, presc_nx;
  logic [1:0]    idx_q, idx_nx;
  logic [FW-1:0] frame_q, frame_nx;
  logic          phase_q, phase_nx;
  logic          wrap, frame_end, blank;
  logic [3:0]    nib, value_nx, sel_nx;

  // Converter: iter_q counts completed iterations; reaching 14 means the
  // scratch holds the final BCD and the next edge hands over to COMMIT.
  always_comb begin
    state_nx = state;
    busy_nx  = busy;
    bin_nx   = bin_q;
    bcd_nx   = bcd_q;
    iter_nx  = iter_q;
    disp_nx  = disp_q;
    adj      = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state)
      IDLE: begin
        if (load) begin
          bin_nx   = (value_in > 14'd9999) ? 14'd9999 : value_in;
          bcd_nx   = '0;
          iter_nx  = '0;
          busy_nx  = 1'b1;
          state_nx = CONVERT;
        end
      end
      CONVERT: begin
        if (iter_q == 4'd14) begin
          state_nx = COMMIT;
        end else begin
          // Top adjusted bit is always zero for inputs <= 9999.
          bcd_nx  = 16'({adj, bin_q[13]});
          bin_nx  = {bin_q[12:0], 1'b0};
          iter_nx = iter_q + 4'd1;
        end
      end
      COMMIT: begin
        disp_nx  = bcd_q;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Scan, blink phase and the next-cycle output values.
  always_comb begin
    wrap      = (presc_q == PW'(SCAN_DIV - 1));
    presc_nx  = wrap ? '0 : presc_q + 1'b1;
    idx_nx    = wrap ? idx_q + 2'd1 : idx_q;
    frame_end = wrap && (idx_q == 2'd3);
    frame_nx  = frame_q;
    phase_nx  = phase_q;
    if (!fever) begin
      // Leaving FEVER re-arms the blink so re-entry starts visible.
      frame_nx = '0;
      phase_nx = 1'b1;
    end else if (frame_end) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_nx = '0;
        phase_nx = ~phase_q;
      end else begin
        frame_nx = frame_q + 1'b1;
      end
    end
    nib   = disp_q[3:0];
    blank = 1'b0;
    case (idx_nx)
      2'd0: begin nib = disp_q[3:0];   blank = 1'b0;                   end
      2'd1: begin nib = disp_q[7:4];   blank = (disp_q[15:4]  == '0);  end
      2'd2: begin nib = disp_q[11:8];  blank = (disp_q[15:8]  == '0);  end
      2'd3: begin nib = disp_q[15:12]; blank = (disp_q[15:12] == '0);  end
      default: begin nib = disp_q[3:0]; blank = 1'b0; end
    endcase
    if (fever)      value_nx = phase_nx ? 4'hA : 4'hF;
    else if (blank) value_nx = 4'hF;
    else            value_nx = nib;
    sel_nx = 4'b0001 << idx_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      bin_q       <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      disp_q      <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      frame_q     <= '0;
      phase_q     <= 1'b1;
      digit_sel   <= 4'b0001;
      digit_value <= 4'h0;
    end else begin
      state       <= state_nx;
      busy        <= busy_nx;
      bin_q       <= bin_nx;
      bcd_q       <= bcd_nx;
      iter_q      <= iter_nx;
      disp_q      <= disp_nx;
      presc_q     <= presc_nx;
      idx_q       <= idx_nx;
      frame_q     <= frame_nx;
      phase_q     <= phase_nx;
      digit_sel   <= sel_nx;
      digit_value <= value_nx;
    end
  end

endmodule
